// File: rtl/clk_ctrl_pkg.sv
// Shared types for the clock/reset controller: FSM state encoding and the
// channel-index width used by the divisor write port.
package clk_ctrl_pkg;

   localparam int unsigned CH_W = 3;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

endpackage

// File: rtl/clk_ctrl_ce_div.sv
// Per-channel clock-enable divider.
// Ports: clk, resetn (async, active low), run (counting allowed),
//        load_we/load_div (divisor register write), ce (one-cycle pulse).
// Period is div+1 cycles; a new divisor is picked up only at the next reload.
module ce_div #(
   parameter int unsigned DIVW     = 16,
   parameter int unsigned DIV_INIT = 0
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            run,
   input  logic            load_we,
   input  logic [DIVW-1:0] load_div,
   output logic            ce
);

   logic [DIVW-1:0] div_q;
   logic [DIVW-1:0] cnt_q;

   // Divisor register: written at any time, even outside RUN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      div_q <= DIVW'(DIV_INIT);
      else if (load_we) div_q <= load_div;
   end

   // Down-counter; held at 0 outside RUN so all channels pulse on RUN entry
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         ce    <= 1'b0;
      end else if (!run) begin
         cnt_q <= '0;
         ce    <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q <= div_q;
         ce    <= 1'b1;
      end else begin
         cnt_q <= cnt_q - DIVW'(1);
         ce    <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_ctrl.sv
// Clock/reset controller: filters PLL lock, sequences the downstream reset
// and generates NCH divided clock-enable pulses while running.
// Ports: clk, resetn (async, active low), pll_locked (async raw lock),
//        cfg_we/cfg_ch/cfg_div (divisor writes), lock_lost_clr,
//        sys_resetn, ce[NCH], lock_ok, lock_lost.
module clk_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int unsigned NCH       = 4,
   parameter int unsigned DIVW      = 16,
   parameter int unsigned DIV_INIT  = 0,
   parameter int unsigned LOCK_FILT = 1024,
   parameter int unsigned RST_HOLD  = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            pll_locked,
   input  logic            cfg_we,
   input  logic [CH_W-1:0] cfg_ch,
   input  logic [DIVW-1:0] cfg_div,
   input  logic            lock_lost_clr,
   output logic            sys_resetn,
   output logic [NCH-1:0]  ce,
   output logic            lock_ok,
   output logic            lock_lost
);

   localparam int unsigned MAX_CNT = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

   logic             sync1;
   logic             lk;
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             run_c;

   // Two-flop lock synchroniser
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1 <= 1'b0;
         lk    <= 1'b0;
      end else begin
         sync1 <= pll_locked;
         lk    <= sync1;
      end
   end

   // FSM state and shared filter/hold counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state: any loss of lock aborts the sequence from every state
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (!lk) begin
         state_n = WAIT_LOCK;
         cnt_n   = '0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               state_n = FILTER;
               cnt_n   = '0;
            end
            FILTER: begin
               if (cnt == CNT_W'(LOCK_FILT - 1)) begin
                  state_n = HOLD;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(RST_HOLD - 1)) begin
                  state_n = RUN;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            RUN:     cnt_n = '0;
            default: begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Gated by lk so reset and enables drop on the same edge that leaves RUN
   assign run_c = (state == RUN) && lk;

   // Registered status outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sys_resetn <= 1'b0;
         lock_ok    <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         sys_resetn <= run_c;
         lock_ok    <= (state == RUN);
         if (lock_lost_clr)              lock_lost <= 1'b0;
         else if ((state == RUN) && !lk) lock_lost <= 1'b1;
      end
   end

   // One divider per channel; out-of-range channel indices match nothing
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ce_div #(
         .DIVW     (DIVW),
         .DIV_INIT (DIV_INIT)
      ) u_div (
         .clk      (clk),
         .resetn   (resetn),
         .run      (run_c),
         .load_we  (cfg_we && (cfg_ch == CH_W'(i))),
         .load_div (cfg_div),
         .ce       (ce[i])
      );
   end

endmodule
